// File: rtl/bus_pkg.sv
// Shared types and constants for the bus device endpoint.
package bus_pkg;

    localparam int ID_W  = 8;
    localparam int PKT_W = 16;

    localparam logic [ID_W-1:0] BCAST    = 8'hFF;
    localparam logic [7:0]      DROP_MAX = 8'hFF;

    // err_flags bit positions
    localparam int ERR_TX_OVF   = 0;
    localparam int ERR_TX_UDF   = 1;
    localparam int ERR_RX_OVF   = 2;
    localparam int ERR_MISROUTE = 3;
    localparam int ERR_W        = 4;

    typedef logic [PKT_W-1:0] pkt_t;

    // Packed so it maps 1:1 onto err_flags {misroute, rx_ovf, tx_udf, tx_ovf}
    typedef struct packed {
        logic misroute;
        logic rx_ovf;
        logic tx_udf;
        logic tx_ovf;
    } err_t;

    // Destination ID sits in the top ID_W bits of a w-bit packet
    function automatic logic [ID_W-1:0] dest_of(input logic [63:0] pkt, input int w);
        return pkt[w-1 -: ID_W];
    endfunction

endpackage

// File: rtl/bus_sync_fifo.sv
// First-word-fall-through synchronous FIFO. Pointers carry one extra wrap bit
// so full/empty are distinguished without a separate counter.
module bus_sync_fifo #(
    parameter int width = 16,
    parameter int depth = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr,
    input  logic [width-1:0]        wr_data,
    input  logic                    rd,
    output logic [width-1:0]        rd_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(depth):0]  count
);

    localparam int AW = $clog2(depth);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [width-1:0] mem [depth];
    logic             wr_en;
    logic             rd_en;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign count = wr_ptr - rd_ptr;

    // A write while full is allowed when the head is consumed on the same edge
    assign wr_en = wr && (!full || rd);
    assign rd_en = rd && !empty;

    // Head is gated so an empty queue presents zeros rather than stale/X storage
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; wrap is plain binary overflow of the extra bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are don't-care after reset since empty masks them
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/bus_dev_endpoint.sv
// Device-side endpoint for one bus slot: TX queue feeding the bus pop side,
// RX queue capturing bus deliveries addressed to this id or broadcast.
module bus_dev_endpoint
    import bus_pkg::*;
#(
    parameter int         pckg_sz   = 16,
    parameter int         depth     = 8,
    parameter int         id        = 0,
    parameter logic [7:0] broadcast = BCAST
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_wr,
    input  logic [pckg_sz-1:0] tx_data,
    output logic               tx_full,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    input  logic               rx_rd,
    output logic [pckg_sz-1:0] rx_data,
    output logic               rx_empty,
    output logic [ERR_W-1:0]   err_flags,
    output logic [7:0]         rx_drop
);

    localparam int CW = $clog2(depth) + 1;

    logic          tx_empty;
    logic          rx_full;
    logic [CW-1:0] tx_count;
    logic [CW-1:0] rx_count;
    logic [ID_W-1:0] rx_dest;
    logic          rx_match;
    logic          rx_accept;
    logic          tx_ovf_evt;
    logic          tx_udf_evt;
    logic          rx_ovf_evt;
    logic          misroute_evt;
    err_t          err_q;
    logic          unused_fifo;

    assign pndng = !tx_empty;

    // TX: the FIFO itself admits a full-queue write only alongside a valid pop
    bus_sync_fifo #(.width(pckg_sz), .depth(depth)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr      (tx_wr),
        .wr_data (tx_data),
        .rd      (pop),
        .rd_data (D_pop),
        .full    (tx_full),
        .empty   (tx_empty),
        .count   (tx_count)
    );

    // RX filter: only our own id or the broadcast id are ever stored
    assign rx_dest   = dest_of(64'(D_push), pckg_sz);
    assign rx_match  = (rx_dest == ID_W'(id)) || (rx_dest == broadcast);
    assign rx_accept = push && rx_match;

    bus_sync_fifo #(.width(pckg_sz), .depth(depth)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr      (rx_accept),
        .wr_data (D_push),
        .rd      (rx_rd),
        .rd_data (rx_data),
        .full    (rx_full),
        .empty   (rx_empty),
        .count   (rx_count)
    );

    // Occupancy counts are available for debug taps but not needed here
    assign unused_fifo = ^{tx_count, rx_count};

    assign tx_ovf_evt   = tx_wr && tx_full && !pop;
    assign tx_udf_evt   = pop && tx_empty;
    assign rx_ovf_evt   = rx_accept && rx_full && !rx_rd;
    assign misroute_evt = push && !rx_match;

    assign err_flags = err_q;

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= '0;
        end else begin
            if (tx_ovf_evt)   err_q.tx_ovf   <= 1'b1;
            if (tx_udf_evt)   err_q.tx_udf   <= 1'b1;
            if (rx_ovf_evt)   err_q.rx_ovf   <= 1'b1;
            if (misroute_evt) err_q.misroute <= 1'b1;
        end
    end

    // Saturating count of accepted packets lost to a full RX queue
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_drop <= '0;
        end else if (rx_ovf_evt && (rx_drop != DROP_MAX)) begin
            rx_drop <= rx_drop + 8'd1;
        end
    end

endmodule
